// File: rtl/fbindct_pipe.sv
// fbindct_pipe: fully pipelined 8-point forward binDCT (shift-add lifting) with
//    valid/ready flow control, rounding output scaling and output saturation.
//    clk, rst                    : clock, synchronous active-high reset
//    x_in, valid_in, ready_in    : input vector handshake
//    y_out, valid_out, ready_out : coefficient handshake, natural order y0..y7
//    sat_out                     : at least one lane of y_out was clipped
module fbindct_pipe #(
   parameter int IN_WIDTH   = 16,
   parameter int OUT_WIDTH  = 16,
   parameter int GUARD_BITS = 4,
   parameter int OUT_SHIFT  = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [IN_WIDTH-1:0]  x_in [0:7],
   input  logic                        valid_in,
   output logic                        ready_in,
   output logic signed [OUT_WIDTH-1:0] y_out [0:7],
   output logic                        valid_out,
   input  logic                        ready_out,
   output logic                        sat_out
);
   localparam int IW = IN_WIDTH + GUARD_BITS;
   // scaling/clipping width wide enough to hold both the rounded value and the output limits
   localparam int CW = (IW + 1 > OUT_WIDTH ? IW + 1 : OUT_WIDTH) + 1;
   localparam logic signed [CW-1:0] RND  = CW'((1 << OUT_SHIFT) >> 1);
   localparam logic signed [CW-1:0] MAXV = CW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [CW-1:0] MINV = ~MAXV;
   typedef logic signed [IW-1:0] w_t;
   w_t s0_d [0:7], s0_q [0:7];
   w_t s1_d [0:7], s1_q [0:7];
   // S2 keeps a0..a4 and a7 in place; slot 5 holds b1 and slot 6 holds b0
   w_t s2_d [0:7], s2_q [0:7];
   w_t s3_d [0:7], s3_q [0:7];
   w_t b0, b1, d0, d1, d2, d3, d4, d5, d6;
   w_t r [0:7];
   logic signed [CW-1:0] v [0:7];
   logic [7:0] clip;
   logic signed [OUT_WIDTH-1:0] y_d [0:7], y_q [0:7];
   logic [4:0] v_d, v_q;
   logic sat_d, sat_q, en;

   assign en        = !v_q[4] || ready_out;
   assign ready_in  = en;
   assign valid_out = v_q[4];
   assign y_out     = y_q;
   assign sat_out   = sat_q;

   always_comb begin
      v_d = {v_q[3:0], valid_in};
      for (int i = 0; i < 8; i++) s0_d[i] = w_t'(x_in[i]);
      for (int i = 0; i < 4; i++) begin
         s1_d[i]     = s0_q[i] + s0_q[7-i];
         s1_d[7-i]   = s0_q[i] - s0_q[7-i];
      end
      b0 = s1_q[6] + (s1_q[5] >>> 2) + (s1_q[5] >>> 3);
      b1 = (b0 >>> 1) + (b0 >>> 3) - s1_q[5];
      s2_d = s1_q;
      s2_d[5] = b1;
      s2_d[6] = b0;
      s3_d[0] = s2_q[0] + s2_q[3];
      s3_d[1] = s2_q[1] + s2_q[2];
      s3_d[2] = s2_q[1] - s2_q[2];
      s3_d[3] = s2_q[0] - s2_q[3];
      s3_d[4] = s2_q[4] + s2_q[5];
      s3_d[5] = s2_q[4] - s2_q[5];
      s3_d[6] = s2_q[7] - s2_q[6];
      s3_d[7] = s2_q[7] + s2_q[6];
      d0 = s3_q[0] + s3_q[1];
      d1 = (d0 >>> 1) - s3_q[1];
      d2 = s3_q[2] - ((s3_q[3] >>> 2) + (s3_q[3] >>> 3));
      d3 = s3_q[3] + (d2 >>> 2) + (d2 >>> 3);
      d4 = s3_q[4] - (s3_q[7] >>> 3);
      d5 = s3_q[5] + (s3_q[6] >>> 1) + (s3_q[6] >>> 2) + (s3_q[6] >>> 3);
      d6 = s3_q[6] - (d5 >>> 1);
      r = '{d0, s3_q[7], d3, d6, d1, d5, d2, d4};
      // bubbles load zero so y_out never shows stale data while valid_out is low
      for (int i = 0; i < 8; i++) begin
         v[i]    = ($signed(CW'(r[i])) + RND) >>> OUT_SHIFT;
         clip[i] = v[i] > MAXV || v[i] < MINV;
         y_d[i]  = v_q[3] ? OUT_WIDTH'(v[i] > MAXV ? MAXV : v[i] < MINV ? MINV : v[i]) : '0;
      end
      sat_d = v_q[3] && |clip;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         sat_q <= 1'b0;
         y_q   <= '{default: '0};
      end else if (en) begin
         v_q   <= v_d;
         sat_q <= sat_d;
         y_q   <= y_d;
      end
      if (en) begin
         s0_q <= s0_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end
endmodule

// File: tb/tb_fbindct_pipe.sv
// tb_fbindct_pipe: self-checking bench for fbindct_pipe (OUT_SHIFT 0 and 2 instances)
module tb_fbindct_pipe;
   typedef logic [7:0][15:0] vec_t;
   typedef struct packed { vec_t y; logic sat; } exp_t;

   logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, ready_out = 1'b1;
   logic signed [15:0] x_in [0:7];
   logic signed [15:0] y0 [0:7], y1 [0:7];
   logic ready_in0, valid_out0, sat_out0, ready_in1, valid_out1, sat_out1;
   vec_t xp, yp0, yp1, snap;
   exp_t q0 [$], q1 [$];
   int n_chk = 0, n_fail = 0, run, w;
   bit seen = 1'b0;

   always #5 clk = ~clk;

   fbindct_pipe dut0 (.clk(clk), .rst(rst), .x_in(x_in), .valid_in(valid_in), .ready_in(ready_in0),
      .y_out(y0), .valid_out(valid_out0), .ready_out(ready_out), .sat_out(sat_out0));
   fbindct_pipe #(.OUT_SHIFT(2)) dut1 (.clk(clk), .rst(rst), .x_in(x_in), .valid_in(valid_in),
      .ready_in(ready_in1), .y_out(y1), .valid_out(valid_out1), .ready_out(ready_out), .sat_out(sat_out1));

   always_comb for (int i = 0; i < 8; i++) begin
      xp[i]  = x_in[i];
      yp0[i] = y0[i];
      yp1[i] = y1[i];
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   function automatic vec_t v8(input int a, b, c, d, e, f, g, h);
      return {16'(h), 16'(g), 16'(f), 16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic vec_t vec(input int k);
      vec_t t;
      for (int i = 0; i < 8; i++) t[i] = 16'(((k * 977 + i * 613 + k * i * 131) % 8191) - 4095);
      return t;
   endfunction

   // reference transform in unbounded integer arithmetic
   function automatic exp_t model(input vec_t xv, input int sh);
      longint x [8], a [8], r [8];
      longint b0, b1, c0, c1, c2, c3, c4, c5, c6, c7, d0, d1, d2, d3, d4, d5, d6, v;
      exp_t e;
      for (int i = 0; i < 8; i++) x[i] = longint'($signed(xv[i]));
      for (int i = 0; i < 4; i++) begin
         a[i] = x[i] + x[7-i];
         a[7-i] = x[i] - x[7-i];
      end
      b0 = a[6] + (a[5] >>> 2) + (a[5] >>> 3);
      b1 = (b0 >>> 1) + (b0 >>> 3) - a[5];
      c0 = a[0] + a[3]; c1 = a[1] + a[2]; c2 = a[1] - a[2]; c3 = a[0] - a[3];
      c4 = a[4] + b1;   c5 = a[4] - b1;   c6 = a[7] - b0;   c7 = a[7] + b0;
      d0 = c0 + c1;
      d1 = (d0 >>> 1) - c1;
      d2 = c2 - ((c3 >>> 2) + (c3 >>> 3));
      d3 = c3 + (d2 >>> 2) + (d2 >>> 3);
      d4 = c4 - (c7 >>> 3);
      d5 = c5 + (c6 >>> 1) + (c6 >>> 2) + (c6 >>> 3);
      d6 = c6 - (d5 >>> 1);
      r = '{d0, c7, d3, d6, d1, d5, d2, d4};
      e.sat = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v = r[i];
         if (sh > 0) v = (v + (64'sd1 <<< (sh - 1))) >>> sh;
         if (v > 32767) begin v = 32767; e.sat = 1'b1; end
         if (v < -32768) begin v = -32768; e.sat = 1'b1; end
         e.y[i] = v[15:0];
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q0.delete();
         q1.delete();
         seen = 1'b0;
      end else begin
         chk("ready_in_rule", ready_in0, !valid_out0 || ready_out);
         chk("ready_in_match", ready_in1, ready_in0);
         chk("valid_out_match", valid_out1, valid_out0);
         if (valid_out0) begin
            seen = 1'b1;
            if (q0.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               chk("y_out_s0", yp0, q0[0].y);
               chk("sat_out_s0", sat_out0, q0[0].sat);
               chk("y_out_s2", yp1, q1[0].y);
               chk("sat_out_s2", sat_out1, q1[0].sat);
               if (ready_out) begin
                  void'(q0.pop_front());
                  void'(q1.pop_front());
               end
            end
         end else if (!seen) begin
            chk("idle_y_s0", yp0, 0);
            chk("idle_sat_s0", sat_out0, 0);
            chk("idle_y_s2", yp1, 0);
         end
         if (valid_in && ready_in0) begin
            q0.push_back(model(xp, 0));
            q1.push_back(model(xp, 2));
         end
      end
   end

   task automatic push(input vec_t xv);
      bit acc;
      int n = 0;
      for (int i = 0; i < 8; i++) x_in[i] = xv[i];
      valid_in = 1'b1;
      do begin
         @(negedge clk);
         acc = ready_in0;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("push_timeout", 0, 1);
      valid_in = 1'b0;
   endtask

   task automatic run_one(input string nm, input vec_t xv, input vec_t e0, input bit s0, input vec_t e1, input bit s1);
      exp_t m;
      int k = 0;
      m = model(xv, 0);
      chk({nm, "_model_s0"}, {m.y, m.sat}, {e0, s0});
      m = model(xv, 2);
      chk({nm, "_model_s2"}, {m.y, m.sat}, {e1, s1});
      push(xv);
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!valid_out0 && k < 10);
      chk({nm, "_latency"}, k, 4);
      chk({nm, "_y_s0"}, yp0, e0);
      chk({nm, "_sat_s0"}, sat_out0, s0);
      chk({nm, "_y_s2"}, yp1, e1);
      chk({nm, "_sat_s2"}, sat_out1, s1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) x_in[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_valid_out", valid_out0, 0);
      chk("reset_sat_out", sat_out0, 0);
      chk("reset_y_out", yp0, 0);
      chk("reset_ready_in", ready_in0, 1);
      @(posedge clk);
      #1;
      run_one("ones", v8(1, 1, 1, 1, 1, 1, 1, 1), v8(8, 0, 0, 0, 0, 0, 0, 0), 0, v8(2, 0, 0, 0, 0, 0, 0, 0), 0);
      run_one("impulse", v8(8, 0, 0, 0, 0, 0, 0, 0), v8(8, 8, 6, 5, 4, 7, -3, -1), 0,
              v8(2, 2, 2, 1, 1, 2, -1, 0), 0);
      run_one("pos_sat", v8(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767),
              v8(32767, 0, 0, 0, 0, 0, 0, 0), 1, v8(32767, 0, 0, 0, 0, 0, 0, 0), 1);
      run_one("neg_sat", v8(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768),
              v8(-32768, 0, 0, 0, 0, 0, 0, 0), 1, v8(-32768, 0, 0, 0, 0, 0, 0, 0), 1);
      repeat (2) @(posedge clk);
      #1;
      run = 0;
      w = 0;
      fork
         for (int k = 0; k < 10; k++) push(vec(k));
         begin
            while (!valid_out0 && w < 20) begin @(negedge clk); w++; end
            while (valid_out0 && run < 20) begin run++; @(negedge clk); end
            chk("stream_consecutive", run, 10);
         end
      join
      fork
         for (int k = 10; k < 20; k++) push(vec(k));
         begin
            repeat (7) @(posedge clk);
            #1 ready_out = 1'b0;
            @(negedge clk);
            snap = yp0;
            chk("stall_ready_in", ready_in0, 0);
            repeat (2) begin
               @(posedge clk);
               @(negedge clk);
               chk("stall_hold_y", yp0, snap);
               chk("stall_hold_valid", valid_out0, 1);
               chk("stall_ready_in", ready_in0, 0);
            end
            @(posedge clk);
            #1 ready_out = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      chk("stream_drained", q0.size(), 0);
      ready_out = 1'b0;
      for (int k = 20; k < 25; k++) push(vec(k));
      chk("pre_reset_valid_out", valid_out0, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midreset_valid_out", valid_out0, 0);
      chk("midreset_ready_in", ready_in0, 1);
      chk("midreset_sat_out", sat_out0, 0);
      @(posedge clk);
      #1 ready_out = 1'b1;
      run_one("post_reset", v8(8, 0, 0, 0, 0, 0, 0, 0), v8(8, 8, 6, 5, 4, 7, -3, -1), 0,
              v8(2, 2, 2, 1, 1, 2, -1, 0), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("final_drained", q0.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
